data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//  Shares one single-port data BlockRam among NUM_CORES ShaderCore data ports.
//  Sits between the cores and the data RAM mux in the top level; one access per cycle.
//  Round-robin grant, fully pipelined; read data returns one cycle after grant.
//  hold input stops new grants while the external loader owns the RAM (run low).
// PARAMETERS
//  NUM_CORES      4   number of requesting cores (1..16)
//  WORD_WIDTH     32  data word width
//  ADDRESS_WIDTH  16  byte address width, forwarded unchanged to the RAM side
// PORTS
//  clock            in   1                        system clock
//  reset            in   1                        synchronous, active-high
//  hold             in   1                        1 = issue no new grants
//  core_req         in   NUM_CORES                per-core request, held until granted
//  core_write       in   NUM_CORES                per-core 1=write, 0=read
//  core_address     in   NUM_CORES*ADDRESS_WIDTH  packed; core i at [i*AW +: AW]
//  core_write_data  in   NUM_CORES*WORD_WIDTH     packed; core i at [i*WW +: WW]
//  core_grant       out  NUM_CORES                one-hot, registered; access accepted
//  core_read_valid  out  NUM_CORES                one-hot, registered; read data valid
//  core_read_data   out  WORD_WIDTH               shared; = ram_read_data
//  ram_address      out  ADDRESS_WIDTH            registered RAM address
//  ram_write        out  1                        registered RAM write enable
//  ram_write_data   out  WORD_WIDTH               registered RAM write data
//  ram_read_data    in   WORD_WIDTH               BlockRam output, 1-cycle latency
// BEHAVIOUR
//  - Reset: core_grant=0, core_read_valid=0, ram_write=0, ram_address=0,
//    ram_write_data=0, rr pointer=0. Any in-flight read is dropped; no valid issued.
//  - Each edge, with hold=0 and core_req!=0, pick the first requester at or after the
//    rr pointer (wrapping modulo NUM_CORES). Register core_grant[i]=1 and drive
//    ram_address/ram_write/ram_write_data from core i. The pointer becomes i+1
//    (wraps to 0 after NUM_CORES-1).
//  - No request, or hold=1: core_grant=0, ram_write=0, ram_address holds, pointer holds.
//  - Handshake: a core samples core_grant at the edge after it appears.
//    - If its core_req is still high in the cycle grant is visible, that is a new request.
//    - The core deasserts req in the grant cycle unless it wants another access.
//    - A request stays pending indefinitely and its fields must be stable while pending.
//  - Read granted at cycle t (grant visible in t): core_read_valid[i]=1 during t+1.
//    core_read_data is valid only in that cycle.
//  - Write granted at cycle t: RAM written at the end of t. No core_read_valid.
//  - Back-to-back grants every cycle, including to the same core when it is the only
//    requester. A read granted at t followed by a write to the same address granted
//    at t+1 returns the old data.
//  - Fairness: with all cores requesting continuously, each core is granted exactly
//    once per NUM_CORES cycles.
//  - hold rising while a read is in flight: that read's valid still issues at t+1.
//  - Pending requests do not change the pointer. Only a grant advances it.
// CONFIGURATION
//  DATA_RAM_ARB_STATS_EN defined: adds three ports.
//    stat_sel    in   4    selects a core
//    stat_grants out  32   grant count for the selected core
//    stat_stalls out  32   cycles that core had req=1 without a grant
//    - Counters are registered, saturate at 0xFFFFFFFF and clear on reset.
//  Undefined: those ports and counters are absent. Arbitration is identical.
// TESTING
//  1. Reset, then core0 reads addr 0x0010 (RAM holds 0xCAFEF00D).
//     -> grant[0] next cycle; read_valid[0]=1 and read_data=0xCAFEF00D one cycle later.
//  2. All 4 cores request reads continuously for 8 cycles.
//     -> grants 0,1,2,3,0,1,2,3; valids follow one cycle behind in the same order.
//  3. core2 writes 0x12345678 to 0x0040, then core1 reads 0x0040.
//     -> read_data=0x12345678; core_read_valid never asserted for the write.
//  4. hold=1 for 5 cycles with core_req=4'b1111.
//     -> no grants, ram_write=0. On release, first grant goes to the core at the pointer.
//  5. Assert reset the cycle after a read grant.
//     -> no read_valid, all outputs zero; the next grant goes to core0.
//  6. With DATA_RAM_ARB_STATS_EN, scenario 2 run for 8 cycles.
//     -> stat_grants=2 and stat_stalls=6 for each core.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one single-port data BlockRam among NUM_CORES cores.
// Define DATA_RAM_ARB_STATS_EN to add per-core grant/stall counters on the stat_* ports.
module data_ram_arbiter #(
  parameter int NUM_CORES     = 4,
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               hold,
  input  logic [NUM_CORES-1:0]               core_req,
  input  logic [NUM_CORES-1:0]               core_write,
  input  logic [NUM_CORES*ADDRESS_WIDTH-1:0] core_address,
  input  logic [NUM_CORES*WORD_WIDTH-1:0]    core_write_data,
  output logic [NUM_CORES-1:0]               core_grant,
  output logic [NUM_CORES-1:0]               core_read_valid,
  output logic [WORD_WIDTH-1:0]              core_read_data,
  output logic [ADDRESS_WIDTH-1:0]           ram_address,
  output logic                               ram_write,
  output logic [WORD_WIDTH-1:0]              ram_write_data,
  input  logic [WORD_WIDTH-1:0]              ram_read_data
`ifdef DATA_RAM_ARB_STATS_EN
  ,
  input  logic [3:0]                         stat_sel,
  output logic [31:0]                        stat_grants,
  output logic [31:0]                        stat_stalls
`endif
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0]         r_ptr;
  logic [NUM_CORES-1:0]     r_grant;
  logic [NUM_CORES-1:0]     r_read_valid;
  logic [ADDRESS_WIDTH-1:0] r_ram_address;
  logic                     r_ram_write;
  logic [WORD_WIDTH-1:0]    r_ram_write_data;

  logic                     w_found_hi;
  logic                     w_found_any;
  logic                     w_issue;
  logic [PTR_W-1:0]         w_sel_hi;
  logic [PTR_W-1:0]         w_sel_any;
  logic [PTR_W-1:0]         w_sel;
  logic [PTR_W-1:0]         w_ptr_next;
  logic [NUM_CORES-1:0]     w_onehot;
  logic                     w_write;
  logic [ADDRESS_WIDTH-1:0] w_address;
  logic [WORD_WIDTH-1:0]    w_write_data;

  // Wrap-around search: first requester at/after the pointer, else the lowest requester.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    w_found_hi   = 1'b0;
    w_found_any  = 1'b0;
    w_sel_hi     = '0;
    w_sel_any    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_req[i] && !w_found_any) begin
        w_found_any = 1'b1;
        w_sel_any   = PTR_W'(i);
      end
      if (core_req[i] && !w_found_hi && i >= int'(r_ptr)) begin
        w_found_hi = 1'b1;
        w_sel_hi   = PTR_W'(i);
      end
    end
    w_sel        = w_found_hi ? w_sel_hi : w_sel_any;
    w_issue      = !hold && w_found_any;
    w_onehot     = '0;
    w_write      = 1'b0;
    w_address    = '0;
    w_write_data = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_issue && w_sel == PTR_W'(i)) begin
        w_onehot[i]  = 1'b1;
        w_write      = core_write[i];
        w_address    = core_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_write_data = core_write_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    w_ptr_next = (int'(w_sel) == NUM_CORES - 1) ? '0 : w_sel + PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr            <= '0;
      r_grant          <= '0;
      r_read_valid     <= '0;
      r_ram_address    <= '0;
      r_ram_write      <= 1'b0;
      r_ram_write_data <= '0;
    end else begin
      // The RAM returns data one cycle after the grant; writes never produce a valid.
      r_read_valid <= r_ram_write ? '0 : r_grant;
      r_grant      <= w_onehot;
      r_ram_write  <= w_write;
      if (w_issue) begin
        r_ram_address    <= w_address;
        r_ram_write_data <= w_write_data;
        r_ptr            <= w_ptr_next;
      end
    end
  end

  assign core_grant      = r_grant;
  assign core_read_valid = r_read_valid;
  assign core_read_data  = ram_read_data;
  assign ram_address     = r_ram_address;
  assign ram_write       = r_ram_write;
  assign ram_write_data  = r_ram_write_data;

`ifdef DATA_RAM_ARB_STATS_EN
  logic [31:0] r_stat_grants [NUM_CORES];
  logic [31:0] r_stat_stalls [NUM_CORES];

  // NOTE: these arrays are individual counters, not RAM, so they are cleared on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_stat_grants[i] <= '0;
        r_stat_stalls[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_onehot[i] && r_stat_grants[i] != '1)
          r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
        if (core_req[i] && !w_onehot[i] && r_stat_stalls[i] != '1)
          r_stat_stalls[i] <= r_stat_stalls[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    stat_stalls = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (stat_sel == 4'(i)) begin
        stat_grants = r_stat_grants[i];
        stat_stalls = r_stat_stalls[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Scoreboard bench for data_ram_arbiter: a round-robin reference model predicts every cycle,
// a negedge monitor compares. Build with DATA_RAM_ARB_STATS_EN to also check the counters.
module tb_data_ram_arbiter;

  localparam int NC = 4;
  localparam int WW = 32;
  localparam int AW = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             hold  = 1'b0;
  logic [NC-1:0]    core_req = '0;
  logic [NC-1:0]    core_write = '0;
  logic [NC*AW-1:0] core_address = '0;
  logic [NC*WW-1:0] core_write_data = '0;
  logic [NC-1:0]    core_grant;
  logic [NC-1:0]    core_read_valid;
  logic [WW-1:0]    core_read_data;
  logic [AW-1:0]    ram_address;
  logic             ram_write;
  logic [WW-1:0]    ram_write_data;
  logic [WW-1:0]    ram_read_data = '0;
`ifdef DATA_RAM_ARB_STATS_EN
  logic [3:0]       stat_sel = '0;
  logic [31:0]      stat_grants;
  logic [31:0]      stat_stalls;
`endif

  data_ram_arbiter #(.NUM_CORES(NC), .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .core_req(core_req), .core_write(core_write), .core_address(core_address),
    .core_write_data(core_write_data), .core_grant(core_grant),
    .core_read_valid(core_read_valid), .core_read_data(core_read_data),
    .ram_address(ram_address), .ram_write(ram_write), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data)
`ifdef DATA_RAM_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [WW-1:0] data; } req_t;
  typedef struct { int due; int core; logic [WW-1:0] data; } rd_t;
  typedef struct { logic [NC-1:0] grant; logic we; logic [AW-1:0] addr; logic [WW-1:0] wdata; } exp_t;

  req_t    pend_q [NC][$];
  rd_t     rd_q[$];
  exp_t    exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      cycle    = 0;

  logic [WW-1:0] ram_mem [256];
  logic [WW-1:0] ref_mem [256];
  int            m_ptr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [WW-1:0] m_wdata = '0;
  int            m_grants [NC];
  int            m_stalls [NC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [NC-1:0] onehot(input int c);
    onehot = '0;
    onehot[c] = 1'b1;
  endfunction

  // Environment: single-port BlockRam, read-first, one-cycle read latency.
  always @(posedge clock) begin
    if (ram_write === 1'b1) ram_mem[ram_address[7:0]] <= ram_write_data;
    ram_read_data <= ram_mem[ram_address[7:0]];
  end

  // Reference model: one expectation per clock edge, from the arbitration rules.
  always @(posedge clock) begin
    exp_t e;
    int   c;
    cycle++;
    e.grant = '0;
    e.we    = 1'b0;
    if (reset) begin
      m_ptr   = 0;
      m_addr  = '0;
      m_wdata = '0;
      rd_q.delete();
      for (int i = 0; i < NC; i++) begin
        m_grants[i] = 0;
        m_stalls[i] = 0;
      end
    end else begin
      c = -1;
      if (!hold)
        for (int k = 0; k < NC; k++)
          if (c < 0 && core_req[(m_ptr + k) % NC]) c = (m_ptr + k) % NC;
      if (c >= 0) begin
        e.grant = onehot(c);
        e.we    = core_write[c];
        m_addr  = core_address[c*AW +: AW];
        m_wdata = core_write_data[c*WW +: WW];
        m_ptr   = (c + 1) % NC;
        m_grants[c]++;
        if (e.we) ref_mem[m_addr[7:0]] = m_wdata;
        else rd_q.push_back('{cycle + 1, c, ref_mem[m_addr[7:0]]});
      end
      for (int i = 0; i < NC; i++)
        if (core_req[i] && i != c) m_stalls[i]++;
    end
    e.addr  = m_addr;
    e.wdata = m_wdata;
    exp_q.push_back(e);
  end

  // Monitor: compares DUT outputs mid-cycle against the queued expectations.
  always @(negedge clock) begin
    exp_t e;
    rd_t  r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("core_grant", 64'(core_grant), 64'(e.grant));
      check("ram_write", 64'(ram_write), 64'(e.we));
      check("ram_address", 64'(ram_address), 64'(e.addr));
      if (e.we) check("ram_write_data", 64'(ram_write_data), 64'(e.wdata));
      if (rd_q.size() > 0 && rd_q[0].due == cycle) begin
        r = rd_q.pop_front();
        check("core_read_valid", 64'(core_read_valid), 64'(onehot(r.core)));
        check("core_read_data", 64'(core_read_data), 64'(r.data));
      end else begin
        check("core_read_valid_idle", 64'(core_read_valid), 64'(0));
      end
    end
  end

  task automatic push_req(input int c, input logic we, input logic [AW-1:0] a, input logic [WW-1:0] d);
    pend_q[c].push_back('{we, a, d});
  endtask

  // Core behaviour: hold a request until its grant is seen, then present the next or drop.
  task automatic drive_cores();
    req_t r;
    for (int i = 0; i < NC; i++) begin
      if (core_req[i] && core_grant[i]) core_req[i] = 1'b0;
      if (!core_req[i] && pend_q[i].size() > 0) begin
        r = pend_q[i].pop_front();
        core_req[i] = 1'b1;
        core_write[i] = r.we;
        core_address[i*AW +: AW] = r.addr;
        core_write_data[i*WW +: WW] = r.data;
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    drive_cores();
  endtask

  function automatic bit busy();
    busy = (core_req != '0) || (rd_q.size() > 0);
    for (int i = 0; i < NC; i++) if (pend_q[i].size() > 0) busy = 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check("idle_within_budget", 64'(n < budget), 64'(1));
    step();
  endtask

  task automatic wait_grant(input int c, input int budget);
    int n = 0;
    while (!core_grant[c] && n < budget) begin
      step();
      n++;
    end
    check("grant_seen", 64'(n < budget), 64'(1));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

`ifdef DATA_RAM_ARB_STATS_EN
  task automatic check_stats();
    for (int i = 0; i < NC; i++) begin
      stat_sel = 4'(i);
      #1;
      check("stat_grants", 64'(stat_grants), 64'(m_grants[i]));
      check("stat_stalls", 64'(stat_stalls), 64'(m_stalls[i]));
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'hA5A5_0000 | 32'(i);
      ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    ram_mem[8'h10] = 32'hCAFE_F00D;
    ref_mem[8'h10] = 32'hCAFE_F00D;

    do_reset(3);

    // Single read after reset.
    push_req(0, 1'b0, 16'h0010, '0);
    wait_idle(50);

    // All four cores read back-to-back from a fresh pointer.
    do_reset(2);
    for (int i = 0; i < NC; i++) begin
      push_req(i, 1'b0, AW'(i), '0);
      push_req(i, 1'b0, AW'(i + 4), '0);
    end
    wait_idle(50);
`ifdef DATA_RAM_ARB_STATS_EN
    check_stats();
`endif

    // Write by core2, read back by core1.
    push_req(2, 1'b1, 16'h0040, 32'h1234_5678);
    wait_idle(50);
    push_req(1, 1'b0, 16'h0040, '0);
    wait_idle(50);

    // Lone requester back-to-back: read, write same address, read again.
    push_req(1, 1'b0, 16'h0040, '0);
    push_req(1, 1'b1, 16'h0040, 32'hDEAD_BEEF);
    push_req(1, 1'b0, 16'h0040, '0);
    wait_idle(50);

    // Hold rises with a read in flight, then all cores wait out five held cycles.
    push_req(3, 1'b0, 16'h0010, '0);
    wait_grant(3, 50);
    hold = 1'b1;
    for (int i = 0; i < NC; i++) push_req(i, 1'b0, AW'(i + 8), '0);
    repeat (5) step();
    hold = 1'b0;
    wait_idle(50);

    // Reset right after a read grant drops the valid and restarts at core0.
    push_req(1, 1'b0, 16'h0005, '0);
    wait_grant(1, 50);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    push_req(2, 1'b0, 16'h0002, '0);
    push_req(0, 1'b0, 16'h0003, '0);
    wait_idle(50);

    // Randomized traffic with random hold.
    for (int t = 0; t < 1500; t++) begin
      hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NC; i++)
        if (pend_q[i].size() < 2 && $urandom_range(0, 2) == 0)
          push_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      step();
    end
    hold = 1'b0;
    wait_idle(500);
`ifdef DATA_RAM_ARB_STATS_EN
    check_stats();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
